// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 6-bit
// parallel-prefix adder between four operand requesters.
module adder_share_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_id,
   output logic [W:0]        rsp_sum,
   output logic [7:0]        op_count
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_e;

   state_e       state_q, state_d;
   logic [1:0]   rr_q, rr_d;
   logic [1:0]   id_q, id_d;
   logic [1:0]   rid_q, rid_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W:0]   sum_q, sum_d;
   logic [7:0]   cnt_q, cnt_d;

   logic [1:0]   win;
   logic         any;
   logic [W:0]   add_s;

   // Shared adder: Kogge-Stone prefix tree over the operand registers
   logic [W-1:0] g0, p0, g1, p1, g2, g3;
   logic [W-1:4] p2;

   assign g0 = a_q & b_q;
   assign p0 = a_q ^ b_q;

   for (genvar i = 0; i < W; i++) begin : g_l1
      if (i >= 1) begin : g_op
         assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
         assign p1[i] = p0[i] & p0[i-1];
      end else begin : g_pass
         assign g1[i] = g0[i];
         assign p1[i] = p0[i];
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_l2
      if (i >= 2) begin : g_op
         assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
         if (i >= 4) begin : g_p
            assign p2[i] = p1[i] & p1[i-2];
         end
      end else begin : g_pass
         assign g2[i] = g1[i];
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_l3
      if (i >= 4) begin : g_op
         assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
      end else begin : g_pass
         assign g3[i] = g2[i];
      end
   end

   assign add_s[0] = p0[0];
   for (genvar i = 1; i < W; i++) begin : g_sum
      assign add_s[i] = p0[i] ^ g3[i-1];
   end
   assign add_s[W] = g3[W-1];

   // Round-robin winner: first valid at or above rr_q, wrapping
   always_comb begin
      win = rr_q;
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req_valid[rr_q + 2'(k)]) begin
            win = rr_q + 2'(k);
            any = 1'b1;
         end
      end
   end

   // Next-state and outputs; grant gated by rst_n so reset clears it
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      id_d      = id_q;
      rid_d     = rid_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      req_ready = '0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any) begin
               req_ready = NREQ'(rst_n) << win;
               a_d       = req_a[win*W +: W];
               b_d       = req_b[win*W +: W];
               id_d      = win;
               rr_d      = win + 2'd1;
               state_d   = CALC;
            end
         end
         CALC: begin
            sum_d   = add_s;
            rid_d   = id_q;
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               cnt_d   = cnt_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         id_q    <= '0;
         rid_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         rid_q   <= rid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp_id   = rid_q;
   assign rsp_sum  = sum_q;
   assign op_count = cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed vectors, corner sequences
// and a randomized run against a cycle-budget reference model.
module tb_adder_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [23:0] req_a;
   logic [23:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [6:0]  rsp_sum;
   logic [7:0]  op_count;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   adder_share_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .op_count  (op_count)
   );

   typedef struct {
      int id;
      int a;
      int b;
      int sum;
   } vec_t;

   vec_t vt[8];
   int   csum[4];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_req(input int i, input int a, input int b);
      req_valid[i] = 1'b1;
      req_a[i*6 +: 6] = 6'(a);
      req_b[i*6 +: 6] = 6'(b);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_op(input int id, input int a, input int b,
                        input int sum, input string nm);
      @(negedge clk);
      set_req(id, a, b);
      rsp_ready = 1'b1;
      #1;
      chk({nm, "_ready"}, req_ready, 32'(1 << id));
      @(negedge clk);
      req_valid[id] = 1'b0;
      #1;
      chk({nm, "_early_valid"}, rsp_valid, 0);
      @(negedge clk);
      #1;
      chk({nm, "_valid"}, rsp_valid, 1);
      chk({nm, "_sum"}, rsp_sum, sum);
      chk({nm, "_id"}, rsp_id, id);
   endtask

   initial begin
      int   ptr, busy, gcyc, eid, esum, cnt, ew, wrapped;
      int   eready, evalid;
      logic [3:0] v;
      logic [5:0] ra[4];
      logic [5:0] rb[4];

      vt[0] = '{0, 63, 63, 126};
      vt[1] = '{1, 0, 0, 0};
      vt[2] = '{2, 32, 32, 64};
      vt[3] = '{3, 1, 62, 63};
      vt[4] = '{0, 45, 27, 72};
      vt[5] = '{2, 63, 0, 63};
      vt[6] = '{1, 31, 33, 64};
      vt[7] = '{3, 17, 5, 22};
      csum = '{30, 42, 54, 66};

      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_sum", rsp_sum, 0);
      chk("rst_id", rsp_id, 0);
      chk("rst_count", op_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(1, 45, 27, 72, "single");
      @(negedge clk);
      #1;
      chk("single_count", op_count, 1);
      chk("single_drop", rsp_valid, 0);

      for (int k = 0; k < 8; k++) begin
         do_op(vt[k].id, vt[k].a, vt[k].b, vt[k].sum,
               $sformatf("vec%0d", k));
      end
      @(negedge clk);
      #1;
      chk("vec_count", op_count, 9);

      // Reset while a response is pending
      @(negedge clk);
      set_req(0, 40, 32);
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      chk("mid_sum_before", rsp_sum, 72);
      set_req(2, 1, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_valid", rsp_valid, 0);
      chk("mid_sum", rsp_sum, 0);
      chk("mid_id", rsp_id, 0);
      chk("mid_ready", req_ready, 0);
      chk("mid_count", op_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      set_req(0, 3, 4);
      set_req(3, 9, 9);
      #1;
      chk("post_rst_grant0", req_ready, 4'b0001);
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_sum", rsp_sum, 7);
      chk("post_rst_id", rsp_id, 0);
      @(negedge clk);
      #1;
      chk("post_rst_grant3", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("post_rst_count", op_count, 2);

      // Full contention from a fresh pointer
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 10 + 7*i, 20 + 5*i);
      rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         chk($sformatf("cont_ready_c%0d", c), req_ready,
             (c % 3 == 0) ? 32'(1 << ((c / 3) % 4)) : 0);
         chk($sformatf("cont_valid_c%0d", c), rsp_valid,
             (c % 3 == 2) ? 1 : 0);
         if (c % 3 == 2) begin
            chk($sformatf("cont_id_c%0d", c), rsp_id, (c / 3) % 4);
            chk($sformatf("cont_sum_c%0d", c), rsp_sum,
                csum[(c / 3) % 4]);
         end
      end
      req_valid = '0;

      // Backpressure, then fairness after a grant to 2
      @(negedge clk);
      @(negedge clk);
      set_req(1, 5, 6);
      rsp_ready = 1'b0;
      #1;
      chk("bp_grant1", req_ready, 4'b0010);
      @(negedge clk);
      req_valid[1] = 1'b0;
      set_req(2, 20, 30);
      #1;
      chk("bp_calc_ready", req_ready, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("bp_valid%0d", k), rsp_valid, 1);
         chk($sformatf("bp_sum%0d", k), rsp_sum, 11);
         chk($sformatf("bp_id%0d", k), rsp_id, 1);
         chk($sformatf("bp_ready%0d", k), req_ready, 0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_valid", rsp_valid, 1);
      chk("bp_release_ready", req_ready, 0);
      @(negedge clk);
      #1;
      chk("bp_after_valid", rsp_valid, 0);
      chk("bp_pending_grant", req_ready, 4'b0100);
      @(negedge clk);
      req_valid[2] = 1'b0;
      set_req(1, 7, 8);
      set_req(3, 9, 10);
      #1;
      chk("fair_calc_ready", req_ready, 0);
      @(negedge clk);
      #1;
      chk("fair_sum2", rsp_sum, 50);
      chk("fair_id2", rsp_id, 2);
      @(negedge clk);
      #1;
      chk("fair_first3", req_ready, 4'b1000);
      @(negedge clk);
      req_valid[3] = 1'b0;
      @(negedge clk);
      #1;
      chk("fair_sum3", rsp_sum, 19);
      chk("fair_id3", rsp_id, 3);
      @(negedge clk);
      #1;
      chk("fair_then1", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      #1;
      chk("fair_sum1", rsp_sum, 15);
      chk("fair_id1", rsp_id, 1);

      // Randomized traffic against the reference model
      do_reset();
      ptr = 0;
      busy = 0;
      gcyc = 0;
      eid = 0;
      esum = 0;
      cnt = 0;
      wrapped = 0;
      v = '0;
      for (int cyc = 0; cyc < 6000 && cnt < 300; cyc++) begin
         if (cyc > 0) @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (!v[i]) begin
               ra[i] = 6'($urandom);
               rb[i] = 6'($urandom);
               if ($urandom_range(0, 1) == 1) v[i] = 1'b1;
            end
            req_a[i*6 +: 6] = ra[i];
            req_b[i*6 +: 6] = rb[i];
         end
         req_valid = v;
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         ew = -1;
         if (busy == 0) begin
            for (int k = 0; k < 4; k++) begin
               if (ew < 0 && v[(ptr + k) % 4]) ew = (ptr + k) % 4;
            end
         end
         eready = (ew >= 0) ? (1 << ew) : 0;
         evalid = (busy != 0 && cyc >= gcyc + 2) ? 1 : 0;
         chk("rnd_ready", req_ready, eready);
         chk("rnd_valid", rsp_valid, evalid);
         if (evalid != 0) begin
            chk("rnd_sum", rsp_sum, esum);
            chk("rnd_id", rsp_id, eid);
         end
         chk("rnd_count", op_count, cnt % 256);
         if (cnt == 256 && wrapped == 0) begin
            chk("wrap_zero", op_count, 0);
            wrapped = 1;
         end
         if (ew >= 0) begin
            busy = 1;
            gcyc = cyc;
            eid = ew;
            esum = ra[ew] + rb[ew];
            ptr = (ew + 1) % 4;
            v[ew] = 1'b0;
         end else if (evalid != 0 && rsp_ready) begin
            busy = 0;
            cnt++;
         end
      end
      chk("rnd_ops_done", (cnt >= 300) ? 1 : 0, 1);
      chk("wrap_seen", wrapped, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one six-bit parallel-prefix `adder` instance between NREQ requesters.
- Requesters are served in round-robin order through a valid/ready handshake.
- Each granted operand pair is registered, summed by the shared adder, and returned as a 7-bit result tagged with the requester ID, over a valid/ready response channel.
- Sits between the operand-producing units and the single arithmetic resource.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 for this revision, so ID width is 2.
- W, 6, operand width; fixed to match the adder. Result width is W+1.

Ports:
- clk  input  1  single system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept; at most one bit set.
- req_a  input  NREQ*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  input  NREQ*W  packed operand B; same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_id  output  2  index of the requester that owns the result.
- rsp_sum  output  W+1  sum; bit W is carry-out.
- op_count  output  8  completed-response counter; wraps.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, op_count=0, operand registers=0.
  - Any in-flight transaction is dropped.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req_ready is combinational: one-hot on the winner, zero if no req_valid.
  - Winner is the first asserted req_valid, searching from rr_ptr upward modulo NREQ.
  - On the cycle with any req_valid: capture the winner's A, B and ID; set rr_ptr = winner+1 mod NREQ; go to CALC.
- CALC:
  - Operand registers drive the adder; req_ready=0.
  - At the clock edge, adder output goes to rsp_sum and captured ID goes to rsp_id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id held stable; req_ready=0.
  - On rsp_valid & rsp_ready: op_count increments (255 -> 0) and state goes to IDLE.
  - rsp_valid falls on the same edge as the handshake.
- Latency: grant in cycle T gives rsp_valid in T+2. Minimum interval between grants is 3 cycles with rsp_ready tied high.
- Requester rules:
  - A requester holds req_valid, req_a and req_b stable until it sees req_ready.
  - Operands are sampled only on the grant cycle; later changes do not affect the result.
- rsp_ready while not in RESP is ignored.
- req_valid while in CALC or RESP is ignored; no grant is issued and rr_ptr is unchanged.
- Arithmetic: unsigned, rsp_sum = A + B, range 0..126, no truncation.
- No combinational path from rsp_ready to req_ready.

Test Plan:
- Reset mid-operation: drive rst_n low while in RESP with rsp_sum=72 -> rsp_valid, rsp_sum, rsp_id, req_ready and op_count go to 0 without waiting for a clock edge. After release, first request on requester 0 gets req_ready[0].
- Single request: req_valid[1], A=45, B=27, grant at T -> req_ready=4'b0010 at T; rsp_valid at T+2 with rsp_sum=72, rsp_id=1; op_count=1 after the handshake.
- Boundary values: 63+63 -> rsp_sum=126 (bit6=1); 0+0 -> 0; 32+32 -> 64; 1+62 -> 63.
- Full contention: all four valid continuously with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0, each 3 cycles apart. Every rsp_id/rsp_sum pair is correct.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_sum and rsp_id stay stable and req_ready stays 0 despite pending requests. When rsp_ready rises, state is IDLE on the next cycle and the pending requester is granted.
- Fairness and wrap: after a grant to requester 2, assert valid on 1 and 3 -> 3 granted first, then 1. Run 256 operations -> op_count wraps to 0.
